// File: rtl/pc_ctrl_if.sv
// Bus between the fetch sequencer and the pipeline/PC register: redirect and stall
// sources in, PC control and flush strobes out.
interface pc_ctrl_if;
    logic        br_req;
    logic [31:0] br_target;
    logic        trap_req;
    logic [31:0] trap_vec;
    logic        ld_use;
    logic        imem_ack;
    logic        imem_req;
    logic        pc_stall;
    logic        br_ctrl;
    logic [31:0] br_addr;
    logic        ifid_stall;
    logic        flush_if;
    logic        flush_id;
    logic        fetch_err;

    modport master (
        output br_req, br_target, trap_req, trap_vec, ld_use, imem_ack,
        input  imem_req, pc_stall, br_ctrl, br_addr, ifid_stall, flush_if, flush_id, fetch_err
    );

    modport slave (
        input  br_req, br_target, trap_req, trap_vec, ld_use, imem_ack,
        output imem_req, pc_stall, br_ctrl, br_addr, ifid_stall, flush_if, flush_id, fetch_err
    );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch-side PC sequencer: arbitrates redirects against stalls and drains stale fetches.
// Optional performance counters are enabled with the PC_CTRL_PERF_EN macro.
module pc_ctrl #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    pc_ctrl_if.slave    bus
`ifdef PC_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_WAIT_MEM = 2'd1,
        S_DRAIN    = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        redirect;
    logic        imem_req_c;
    logic        pc_stall_c;
    logic        br_ctrl_c;
    logic [31:0] br_addr_c;
    logic        ifid_stall_c;
    logic        flush_if_c;
    logic        flush_id_c;
    logic        fetch_err_c;

    assign redirect = bus.trap_req | bus.br_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Everything below is forced low while reset is held, so the PC register sees no activity.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = 8'd0;
        imem_req_c   = 1'b0;
        pc_stall_c   = 1'b0;
        br_ctrl_c    = 1'b0;
        br_addr_c    = 32'd0;
        ifid_stall_c = 1'b0;
        flush_if_c   = 1'b0;
        flush_id_c   = 1'b0;
        fetch_err_c  = 1'b0;

        if (rst) begin
            if (redirect) begin
                br_ctrl_c  = 1'b1;
                br_addr_c  = bus.trap_req ? bus.trap_vec : bus.br_target;
                flush_if_c = 1'b1;
                flush_id_c = 1'b1;
            end

            case (state_q)
                S_RUN: begin
                    imem_req_c = 1'b1;
                    if (redirect) begin
                        state_d = bus.imem_ack ? S_RUN : S_DRAIN;
                    end else if (!bus.imem_ack) begin
                        pc_stall_c   = 1'b1;
                        ifid_stall_c = 1'b1;
                        state_d      = S_WAIT_MEM;
                    end
                end

                S_WAIT_MEM: begin
                    imem_req_c = 1'b1;
                    if (redirect) begin
                        state_d = bus.imem_ack ? S_RUN : S_DRAIN;
                    end else if (bus.imem_ack) begin
                        state_d = S_RUN;
                    end else begin
                        pc_stall_c   = 1'b1;
                        ifid_stall_c = 1'b1;
                        // Timeout is reported but the fetch keeps waiting.
                        if (wait_cnt_q == WAIT_LAST) begin
                            fetch_err_c = 1'b1;
                            wait_cnt_d  = 8'd0;
                        end else begin
                            wait_cnt_d  = wait_cnt_q + 8'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    if (redirect) begin
                        state_d = bus.imem_ack ? S_RUN : S_DRAIN;
                    end else begin
                        pc_stall_c   = 1'b1;
                        ifid_stall_c = 1'b1;
                        if (bus.imem_ack) begin
                            flush_if_c = 1'b1;
                            state_d    = S_RUN;
                        end
                    end
                end

                default: begin
                    state_d = S_RUN;
                end
            endcase

            // Load-use stalls the front end and bubbles ID/EX; a redirect wins instead.
            if (!redirect && bus.ld_use) begin
                pc_stall_c   = 1'b1;
                ifid_stall_c = 1'b1;
                flush_id_c   = 1'b1;
            end
        end
    end

    assign bus.imem_req   = imem_req_c;
    assign bus.pc_stall   = pc_stall_c;
    assign bus.br_ctrl    = br_ctrl_c;
    assign bus.br_addr    = br_addr_c;
    assign bus.ifid_stall = ifid_stall_c;
    assign bus.flush_if   = flush_if_c;
    assign bus.flush_id   = flush_id_c;
    assign bus.fetch_err  = fetch_err_c;

`ifdef PC_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_redirect_q, perf_redirect_d;

    assign perf_stall_d    = perf_stall_q    + {31'd0, pc_stall_c};
    assign perf_redirect_d = perf_redirect_q + {31'd0, br_ctrl_c};

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q    <= 32'd0;
            perf_redirect_q <= 32'd0;
        end else begin
            perf_stall_q    <= perf_stall_d;
            perf_redirect_q <= perf_redirect_d;
        end
    end

    assign perf_stall_cnt    = perf_stall_q;
    assign perf_redirect_cnt = perf_redirect_q;
`endif

endmodule
